mem_port_ctrl: RTL and testbench
================================

Name: mem_port_ctrl

Overview:
- Memory access sequencer between the multicycle control unit and the unified instruction/data memory.
- Turns the control unit's one-state memRead/memWrite/IorD/IRwrite strobes into a req/ack transaction with a variable-latency memory.
- Owns the instruction register (IR) and memory data register (MDR).
- Drives mem_busy. The control unit holds its present state, and the datapath gates PC/register writes, while mem_busy=1.

Parameters:
- DW, 16: data/instruction width.
- AW, 12: address width; the data address is IR[AW-1:0].
- TIMEOUT, 255: maximum REQ cycles without ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- init_n  in  1  asynchronous active-low reset.
- memRead  in  1  read strobe from the control unit.
- memWrite  in  1  write strobe from the control unit.
- IorD  in  1  address select: 0=pc, 1=IR[AW-1:0].
- IRwrite  in  1  capture the read data into IR as well as MDR.
- pc  in  AW  program counter.
- wdata  in  DW  store data (accumulator/register output).
- m_req  out  1  memory request.
- m_we  out  1  memory write enable; valid while m_req=1.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_ack  in  1  memory completion; rdata valid in the same cycle.
- m_rdata  in  DW  memory read data.
- ir  out  DW  instruction register.
- mdr  out  DW  memory data register.
- mem_busy  out  1  stall to the control unit (combinational).
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset (async, init_n=0): state=IDLE. m_req, m_we, mem_done and mem_err are 0. m_addr, m_wdata, ir, mdr and the timer are 0. m_req must drop in the same cycle reset asserts, including mid-transaction. No transaction resumes after reset.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If memRead|memWrite at a clock edge: latch addr = IorD ? ir[AW-1:0] : pc, latch m_wdata = wdata, latch we = memWrite, latch ir_cap = IRwrite & ~memWrite. Clear the timer and go to REQ.
  - If memRead and memWrite are both high: the write wins, mem_err is set, ir_cap=0.
- REQ:
  - m_req=1; m_we, m_addr and m_wdata hold the latched values, stable until ack.
  - On m_ack: a read loads mdr <= m_rdata, and ir <= m_rdata if ir_cap; a write leaves ir and mdr unchanged. Then go to DONE.
  - Otherwise the timer increments. When TIMEOUT!=0 and the timer reaches TIMEOUT with no ack: drop m_req, set mem_err, leave ir/mdr unchanged, go to DONE.
- DONE: mem_done=1 for exactly one cycle, m_req=0, then IDLE. Strobes present in DONE are ignored; they belong to the finished access.
- mem_busy = (IDLE & (memRead|memWrite)) | REQ. It is 0 in DONE, so the control unit advances on the edge that leaves DONE.
- Latency from strobe to mem_done, with ack on the first REQ cycle:
  - Cycle 0: strobe in IDLE.
  - Cycle 1: REQ, ack.
  - Cycle 2: DONE.
  - Total: 3 cycles per access; each extra wait cycle adds 1.
- ir/mdr change only on an acked read. ir is stable across the ID and execute states.
- Back-to-back accesses: the next strobe is sampled in the IDLE cycle after DONE; there is no overlap.
- m_ack outside REQ is ignored.
- mem_err clears only on reset.
- Widths: all registers are exact width; the timer is 8 bits and saturates at 255.

Test Plan:
1. Fetch, zero wait: pc=0x010, memRead=1, IorD=0, IRwrite=1, m_ack on the first REQ cycle with m_rdata=0xC123 -> m_addr=0x010, m_we=0; ir=mdr=0xC123 at DONE; mem_busy high exactly 2 cycles; mem_done one pulse.
2. Load with 3 wait states: ir=0x0ABC, memRead=1, IorD=1, IRwrite=0, ack after 3 REQ cycles with rdata=0x5A5A -> m_addr=0xABC held for 4 cycles; mdr=0x5A5A; ir unchanged; mem_busy high 5 cycles.
3. Store: ir=0x1123, wdata=0xBEEF, memWrite=1, IorD=1 -> m_req=1, m_we=1, m_addr=0x123, m_wdata=0xBEEF until ack; ir/mdr unchanged; mem_err=0.
4. Timeout: TIMEOUT=4, read with no ack -> m_req drops after 4 REQ cycles; mem_err=1; mdr keeps its prior value; mem_done pulses; mem_err still 1 after the next good access.
5. Reset mid-REQ: init_n low during REQ of a fetch -> m_req=0 and ir=mdr=0 immediately; state IDLE; a late m_ack after release is ignored.
6. Conflict and back-to-back: memRead and memWrite both high -> write performed, mem_err=1; strobe held through DONE -> no second transaction; a new strobe in the following IDLE cycle starts REQ.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: memory access sequencer between the multicycle control unit
// and the unified instruction/data memory. Converts one-state read/write
// strobes into a req/ack handshake with a variable-latency memory, owns IR and
// MDR, and stalls the control unit through mem_busy while an access is open.
module mem_port_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 12,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          memRead,
  input  logic          memWrite,
  input  logic          IorD,
  input  logic          IRwrite,
  input  logic [AW-1:0] pc,
  input  logic [DW-1:0] wdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] mdr,
  output logic          mem_busy,
  output logic          mem_done,
  output logic          mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Access captured in IDLE and held unchanged for the whole REQ phase.
  typedef struct packed {
    logic          we;
    logic          ir_cap;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  // Watchdog limit; a zero limit never matches because the enable gates it.
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam bit         TO_EN  = (TIMEOUT != 0);

  state_t        r_state;
  state_t        w_nxt;
  req_t          r_req;
  logic [7:0]    r_timer;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_mdr;
  logic          r_err;

  logic          w_strobe;
  logic          w_conflict;
  logic [7:0]    w_tmr_inc;
  logic          w_timeout;

  assign w_strobe   = memRead | memWrite;
  assign w_conflict = memRead & memWrite;
  // Timer saturates so a disabled watchdog cannot wrap.
  assign w_tmr_inc  = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;
  // Abort on the REQ cycle that would bring the wait count up to the limit.
  assign w_timeout  = TO_EN && (w_tmr_inc == TO_LIM);

  // State register; reset drops m_req immediately since m_req decodes state.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_nxt    = r_state;
    m_req    = 1'b0;
    m_we     = 1'b0;
    mem_busy = 1'b0;
    mem_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_busy = w_strobe;
        if (w_strobe) w_nxt = S_REQ;
      end
      S_REQ: begin
        m_req    = 1'b1;
        m_we     = r_req.we;
        mem_busy = 1'b1;
        if (m_ack || w_timeout) w_nxt = S_DONE;
      end
      S_DONE: begin
        // Strobes still high here belong to the access just finished.
        mem_done = 1'b1;
        w_nxt    = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Request capture, wait timer, IR/MDR load and sticky error.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_req   <= '0;
      r_timer <= 8'd0;
      r_ir    <= '0;
      r_mdr   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            // A simultaneous read+write resolves as a write and is flagged.
            r_req.we     <= memWrite;
            r_req.ir_cap <= IRwrite & ~memWrite;
            r_req.addr   <= IorD ? r_ir[AW-1:0] : pc;
            r_req.wdata  <= wdata;
            r_timer      <= 8'd0;
            if (w_conflict) r_err <= 1'b1;
          end
        end
        S_REQ: begin
          if (m_ack) begin
            if (!r_req.we) begin
              r_mdr <= m_rdata;
              if (r_req.ir_cap) r_ir <= m_rdata;
            end
          end else begin
            r_timer <= w_tmr_inc;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_addr  = r_req.addr;
  assign m_wdata = r_req.wdata;
  assign ir      = r_ir;
  assign mdr     = r_mdr;
  assign mem_err = r_err;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl. Each access pushes its expected outcome
// (address, direction, data, IR/MDR/error after completion, REQ and busy cycle
// counts) onto a scoreboard; the entry is checked while REQ is up and popped
// when mem_done pulses. The memory side is modelled by driving m_ack directly.
module tb_mem_port_ctrl;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          init_n;
  logic          memRead, memWrite, IorD, IRwrite;
  logic [AW-1:0] pc;
  logic [DW-1:0] wdata;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata, ir, mdr;
  logic          mem_busy, mem_done, mem_err;

  always #5 clk = ~clk;

  mem_port_ctrl #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .init_n(init_n),
    .memRead(memRead), .memWrite(memWrite), .IorD(IorD), .IRwrite(IRwrite),
    .pc(pc), .wdata(wdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .ir(ir), .mdr(mdr),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ir;
    logic [DW-1:0] mdr;
    logic          err;
    int            reqs;
    int            busy;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  // Reference copies of the architectural state, advanced from stimulus only.
  logic [DW-1:0] mir  = '0;
  logic [DW-1:0] mmdr = '0;
  logic          merr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access: strobes held until mem_done is seen (the control unit is
  // stalled meanwhile), ack on REQ cycle index ack_after (-1 = never).
  task automatic access(input logic rd, input logic wr, input logic iord, input logic irw,
                        input logic [AW-1:0] a_pc, input logic [DW-1:0] wd,
                        input int ack_after, input logic [DW-1:0] rdat);
    exp_t e;
    int   r;
    int   busy;
    logic req_now;
    bit   done;
    e.addr  = iord ? mir[AW-1:0] : a_pc;
    e.we    = wr;
    e.wdata = wd;
    if (rd && wr) merr = 1'b1;
    if (ack_after >= 0) begin
      if (!wr) begin
        mmdr = rdat;
        if (irw) mir = rdat;
      end
      e.reqs = ack_after + 1;
    end else begin
      merr   = 1'b1;
      e.reqs = TO;
    end
    e.ir   = mir;
    e.mdr  = mmdr;
    e.err  = merr;
    e.busy = e.reqs + 1;
    sb.push_back(e);

    @(negedge clk);
    memRead = rd; memWrite = wr; IorD = iord; IRwrite = irw;
    pc = a_pc; wdata = wd; m_ack = 1'b0;
    #1;
    busy = int'(mem_busy);
    r    = 0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      req_now = m_req;
      m_ack   = req_now && (r == ack_after);
      m_rdata = m_ack ? rdat : 16'hDEAD;
      #1;
      busy += int'(mem_busy);
      if (req_now) begin
        chk("req_addr", 32'(m_addr), 32'(sb[0].addr));
        chk("req_we", 32'(m_we), 32'(sb[0].we));
        chk("req_wdata", 32'(m_wdata), 32'(sb[0].wdata));
        r++;
      end
      if (mem_done) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("done_req_low", 32'(m_req), 32'd0);
          chk("done_ir", 32'(ir), 32'(e.ir));
          chk("done_mdr", 32'(mdr), 32'(e.mdr));
          chk("done_err", 32'(mem_err), 32'(e.err));
          chk("req_cycles", 32'(r), 32'(e.reqs));
          chk("busy_cycles", 32'(busy), 32'(e.busy));
        end
      end
    end
    if (!done) chk("done_within_budget", 32'd0, 32'd1);
    m_ack = 1'b0;
  endtask

  // Control unit moves on: strobes drop, nothing may be in flight.
  task automatic idle();
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0; IRwrite = 1'b0; IorD = 1'b0; m_ack = 1'b0;
    #1;
    chk("idle_req", 32'(m_req), 32'd0);
    chk("idle_busy", 32'(mem_busy), 32'd0);
    chk("idle_done", 32'(mem_done), 32'd0);
  endtask

  initial begin
    init_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; IorD = 1'b0; IRwrite = 1'b0;
    pc = '0; wdata = '0; m_ack = 1'b0; m_rdata = '0;
    #3;
    chk("rst_req", 32'(m_req), 32'd0);
    chk("rst_we", 32'(m_we), 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    chk("rst_wdata", 32'(m_wdata), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_mdr", 32'(mdr), 32'd0);
    chk("rst_done", 32'(mem_done), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    @(negedge clk);
    init_n = 1'b1;

    // 1: zero-wait fetch
    access(1'b1, 1'b0, 1'b0, 1'b1, 12'h010, 16'h0000, 0, 16'hC123);
    idle();

    // 2: fetch IR=0x0ABC, then data load through IR with 3 wait states
    access(1'b1, 1'b0, 1'b0, 1'b1, 12'h020, 16'h0000, 0, 16'h0ABC);
    idle();
    access(1'b1, 1'b0, 1'b1, 1'b0, 12'h021, 16'h0000, 3, 16'h5A5A);
    idle();

    // 3: fetch IR=0x1123, then store 0xBEEF to 0x123
    access(1'b1, 1'b0, 1'b0, 1'b1, 12'h022, 16'h0000, 0, 16'h1123);
    idle();
    access(1'b0, 1'b1, 1'b1, 1'b0, 12'h023, 16'hBEEF, 1, 16'h9999);
    idle();

    // 4: read never acked -> watchdog abort; error survives a good fetch
    access(1'b1, 1'b0, 1'b0, 1'b0, 12'h030, 16'h0000, -1, 16'h0000);
    idle();
    access(1'b1, 1'b0, 1'b0, 1'b1, 12'h031, 16'h0000, 0, 16'h2222);
    idle();

    // 5: reset asserted mid-REQ of a fetch, then a stray late ack
    @(negedge clk);
    memRead = 1'b1; IorD = 1'b0; IRwrite = 1'b1; pc = 12'h050;
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(m_req), 32'd1);
    #2;
    init_n = 1'b0;
    #1;
    chk("midrst_req", 32'(m_req), 32'd0);
    chk("midrst_ir", 32'(ir), 32'd0);
    chk("midrst_mdr", 32'(mdr), 32'd0);
    chk("midrst_err", 32'(mem_err), 32'd0);
    memRead = 1'b0; IRwrite = 1'b0;
    mir = '0; mmdr = '0; merr = 1'b0;
    @(negedge clk);
    init_n = 1'b1; m_ack = 1'b1; m_rdata = 16'h7777;
    @(negedge clk);
    #1;
    chk("late_ack_req", 32'(m_req), 32'd0);
    chk("late_ack_mdr", 32'(mdr), 32'd0);
    chk("late_ack_done", 32'(mem_done), 32'd0);
    m_ack = 1'b0;

    // 6: read+write conflict performs the write; strobes held through DONE
    //    start nothing, and a new strobe right after DONE starts at once
    access(1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 16'h1234, 0, 16'hFFFF);
    access(1'b1, 1'b0, 1'b0, 1'b1, 12'h041, 16'h0000, 0, 16'h3333);
    idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
